// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: register-file geometry and operand types.
package rv32_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef logic [XLEN-1:0]       word_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage : rv32_pkg

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: address mux, x0 forced to zero,
// and optional same-cycle write forwarding (macro REGFILE_WRITE_BYPASS_EN).
module regfile_read_port
   import rv32_pkg::*;
#(
   parameter int unsigned DATA_W = XLEN,
   parameter int unsigned ADDR_W = REG_ADDR_W,
   parameter int unsigned NREGS  = 2**ADDR_W
) (
   input  logic [DATA_W-1:0] regs [1:NREGS-1],
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              fwd_en,
   input  logic [ADDR_W-1:0] fwd_addr,
   input  logic [DATA_W-1:0] fwd_data,
   output logic [DATA_W-1:0] rd_data_c
);

`ifdef REGFILE_WRITE_BYPASS_EN
   // Select stored value, or the in-flight write data when it targets this address.
   always_comb begin
      rd_data_c = '0;
      if (rd_addr != ADDR_W'(REG_ZERO)) begin
         if (fwd_en && (fwd_addr == rd_addr)) begin
            rd_data_c = fwd_data;
         end else begin
            rd_data_c = regs[rd_addr];
         end
      end
   end
`else
   // Forwarding inputs have no consumer in this build.
   logic unused_fwd;
   assign unused_fwd = ^{fwd_en, fwd_addr, fwd_data};

   // Select stored value; x0 always reads zero.
   always_comb begin
      rd_data_c = '0;
      if (rd_addr != ADDR_W'(REG_ZERO)) begin
         rd_data_c = regs[rd_addr];
      end
   end
`endif

endmodule : regfile_read_port

// File: rtl/register_file.sv
// RV32I integer register file: 1 synchronous write port, 2 combinational read
// ports, x0 hardwired to zero. Optional write-to-read forwarding is enabled by
// defining REGFILE_WRITE_BYPASS_EN.
module register_file
   import rv32_pkg::*;
#(
   parameter int unsigned DATA_W = XLEN,
   parameter int unsigned ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_ena,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr0,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1
);

   localparam int unsigned NREGS = 2**ADDR_W;

   // No storage for x0; entries 1..NREGS-1 only.
   logic [DATA_W-1:0] regs [1:NREGS-1];
   logic              fwd_en;

   // Storage update: async clear, write on clock edge, x0 writes dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ena && (wr_addr != ADDR_W'(REG_ZERO))) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Forwarding qualifier; suppressed in reset so reads stay zero.
   always_comb begin
      fwd_en = wr_ena && !rst && (wr_addr != ADDR_W'(REG_ZERO));
   end

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
   ) u_rd_port0 (
      .regs      (regs),
      .rd_addr   (rd_addr0),
      .fwd_en    (fwd_en),
      .fwd_addr  (wr_addr),
      .fwd_data  (wr_data),
      .rd_data_c (rd_data0)
   );

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
   ) u_rd_port1 (
      .regs      (regs),
      .rd_addr   (rd_addr1),
      .fwd_en    (fwd_en),
      .fwd_addr  (wr_addr),
      .fwd_data  (wr_data),
      .rd_data_c (rd_data1)
   );

endmodule : register_file

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read data,
// a monitor process compares it against the read ports at each sample event.
module tb_register_file;

   logic        clk;
   logic        rst;
   logic        wr_ena;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr0;
   logic [4:0]  rd_addr1;
   logic [31:0] rd_data0;
   logic [31:0] rd_data1;

   register_file dut (
      .clk      (clk),
      .rst      (rst),
      .wr_ena   (wr_ena),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr0 (rd_addr0),
      .rd_addr1 (rd_addr1),
      .rd_data0 (rd_data0),
      .rd_data1 (rd_data1)
   );

   typedef struct {
      int          scen;
      int          port;
      logic [4:0]  addr;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb_q[$];
   event        sample_ev;
   int          applied = 0;
   int          miscompares = 0;
   logic [31:0] model [0:31];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: on each sample event, drain and compare all queued expectations.
   initial begin
      forever begin
         @(sample_ev);
         #1;
         while (sb_q.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = sb_q.pop_front();
            got = (e.port == 0) ? rd_data0 : rd_data1;
            applied++;
            if (got !== e.exp) begin
               miscompares++;
               $display("FAIL scen%0d port%0d addr=%0d got=%h exp=%h",
                        e.scen, e.port, e.addr, got, e.exp);
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   // Drive both read addresses now, queue expectations, trigger the monitor.
   task automatic sample(input int scen, input logic [4:0] a0, input logic [31:0] e0,
                         input logic [4:0] a1, input logic [31:0] e1);
      exp_t e;
      rd_addr0 = a0;
      rd_addr1 = a1;
      e.scen = scen; e.port = 0; e.addr = a0; e.exp = e0; sb_q.push_back(e);
      e.scen = scen; e.port = 1; e.addr = a1; e.exp = e1; sb_q.push_back(e);
      -> sample_ev;
      #2;
   endtask

   task automatic read_chk(input int scen, input logic [4:0] a0, input logic [31:0] e0,
                           input logic [4:0] a1, input logic [31:0] e1);
      @(negedge clk);
      sample(scen, a0, e0, a1, e1);
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_ena  = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(posedge clk);
      #1;
      wr_ena = 1'b0;
      if (a != 5'd0) model[a] = d;
   endtask

   initial begin
      rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr0 = '0; rd_addr1 = '0;
      for (int i = 0; i < 32; i++) model[i] = '0;

      // 1: reset for two cycles, then all reads zero.
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) read_chk(1, 5'(i), 32'h0, 5'(31 - i), 32'h0);

      // 2: write -(i+1) to every address; x0 write discarded.
      for (int i = 0; i < 32; i++) do_write(5'(i), 32'(-(i + 1)));
      for (int i = 0; i < 32; i++) read_chk(2, 5'(i), model[i], 5'(31 - i), model[31 - i]);
      read_chk(2, 5'd1, 32'hFFFF_FFFE, 5'd31, 32'hFFFF_FFE0);
      read_chk(2, 5'd0, 32'h0, 5'd0, 32'h0);
      read_chk(2, 5'd9, 32'hFFFF_FFF6, 5'd9, 32'hFFFF_FFF6);

      // 3: x0 write ignored.
      do_write(5'd0, 32'hDEAD_BEEF);
      read_chk(3, 5'd0, 32'h0, 5'd0, 32'h0);

      // 4: wr_ena=0 changes nothing.
      @(negedge clk);
      wr_ena = 1'b0; wr_addr = 5'd5; wr_data = 32'h1234_5678;
      @(posedge clk);
      read_chk(4, 5'd5, 32'hFFFF_FFFA, 5'd5, 32'hFFFF_FFFA);

      // 5: same-cycle write/read of x7; port1 reads a different register.
      @(negedge clk);
      wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
`ifdef REGFILE_WRITE_BYPASS_EN
      sample(5, 5'd7, 32'hA5A5_A5A5, 5'd8, 32'hFFFF_FFF7);
`else
      sample(5, 5'd7, 32'hFFFF_FFF8, 5'd8, 32'hFFFF_FFF7);
`endif
      @(posedge clk);
      #1;
      wr_ena = 1'b0;
      model[7] = 32'hA5A5_A5A5;
      read_chk(5, 5'd7, 32'hA5A5_A5A5, 5'd7, 32'hA5A5_A5A5);

      // 5b: same-cycle write to x0 never forwards.
      @(negedge clk);
      wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
      sample(5, 5'd0, 32'h0, 5'd0, 32'h0);
      @(posedge clk);
      #1;
      wr_ena = 1'b0;

      // 6: more writes, then async reset between edges clears everything at once.
      do_write(5'd3, 32'h0BAD_F00D);
      do_write(5'd30, 32'hCAFE_0001);
      read_chk(6, 5'd3, 32'h0BAD_F00D, 5'd30, 32'hCAFE_0001);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) model[i] = '0;
      sample(6, 5'd3, 32'h0, 5'd30, 32'h0);
      for (int i = 0; i < 32; i++) begin
         rd_addr0 = 5'(i);
         sample(6, 5'(i), 32'h0, 5'(31 - i), 32'h0);
      end

      // Reset released mid-sequence: first write lands on next posedge.
      @(negedge clk);
      rst = 1'b0;
      read_chk(6, 5'd3, 32'h0, 5'd30, 32'h0);
      do_write(5'd3, 32'h1357_9BDF);
      read_chk(6, 5'd3, 32'h1357_9BDF, 5'd30, 32'h0);

      #5;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule : tb_register_file
